mask_gen: RTL and testbench

Mask generator feeding the pixel-masking stage of the ProCam pipeline. It watches the DVI pixel coordinate stream and emits a one-bit mask per valid pixel. The mask is the union of up to NUM_RECT programmable rectangles, optionally inverted. Latency is exactly 6 cycles, which matches the masking stage's 6-cycle DVI delay line, so mask and pixel data meet without further alignment. Configuration is double-buffered and takes effect only at frame start, so a frame is never masked with a half-written configuration.

---
 rtl/mask_pkg.sv | 33 +++
 rtl/mask_gen_if.sv | 29 ++
 rtl/mask_rect_cmp.sv | 31 +++
 rtl/mask_gen.sv | 197 +++++++++++++++++++
 tb/tb_mask_gen.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mask_pkg.sv
// mask_pkg: shared constants and types for the mask generator and the
// masking stage that consumes its output.
//   CFG_ADDR_CTRL  : config address of the control word (enables + invert)
//   CFG_INVERT_BIT : bit of the control word that inverts the final mask
//   PIPE_LAT       : mask latency; the masking stage's delay line must match
//   cfg_state_e    : pending-bank state (CLEAN = pending equals active)
//   rect_t         : one rectangle's inclusive bounds
package mask_pkg;

    localparam int unsigned COORD_W        = 10;
    localparam int unsigned CFG_ADDR_W     = 5;
    localparam logic [4:0]  CFG_ADDR_CTRL  = 5'd31;
    localparam int unsigned CFG_INVERT_BIT = 9;
    localparam int unsigned PIPE_LAT       = 6;
    localparam int unsigned MAX_RECT       = 7;

    typedef enum logic {CLEAN, DIRTY} cfg_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
    } rect_t;

    // Inclusive unsigned range test; lo > hi yields 0.
    function automatic logic in_range(input logic [COORD_W-1:0] v,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/mask_gen_if.sv
// mask_gen_if: pixel coordinate input, config write port and mask output of
// the mask generator.
//   slave  : the mask generator side
//   master : the side that drives pixels/config and consumes the mask
interface mask_gen_if;

    logic       iDVI_VAL;
    logic [9:0] iDVI_X;
    logic [9:0] iDVI_Y;
    logic       iCFG_WE;
    logic [4:0] iCFG_ADDR;
    logic [9:0] iCFG_DATA;
    logic       oMASK;
    logic       oMASK_VAL;
    logic [9:0] oMASK_X;
    logic [9:0] oMASK_Y;
    logic       oCFG_PENDING;

    modport slave (
        input  iDVI_VAL, iDVI_X, iDVI_Y, iCFG_WE, iCFG_ADDR, iCFG_DATA,
        output oMASK, oMASK_VAL, oMASK_X, oMASK_Y, oCFG_PENDING
    );

    modport master (
        output iDVI_VAL, iDVI_X, iDVI_Y, iCFG_WE, iCFG_ADDR, iCFG_DATA,
        input  oMASK, oMASK_VAL, oMASK_X, oMASK_Y, oCFG_PENDING
    );

endinterface

// File: rtl/mask_rect_cmp.sv
// mask_rect_cmp: registered inclusive hit test of one pixel against one
// rectangle.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_x, i_y       : pixel coordinate
//   i_rect         : rectangle bounds
//   o_hit          : registered hit (one cycle after the inputs)
module mask_rect_cmp
    import mask_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  rect_t              i_rect,
    output logic               o_hit
);

    logic r_hit;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hit <= 1'b0;
        end else begin
            r_hit <= in_range(i_x, i_rect.x0, i_rect.x1) &&
                     in_range(i_y, i_rect.y0, i_rect.y1);
        end
    end

    assign o_hit = r_hit;

endmodule

// File: rtl/mask_gen.sv
// mask_gen: per-pixel mask from the union of NUM_RECT rectangles, optionally
// inverted, with double-buffered configuration swapped at frame start.
//   iCLK, iRST_N : pixel clock, synchronous active-low reset
//   bus          : pixel coordinates in, config writes in, mask out
// Fixed latency of PIPE_LAT cycles, one pixel per clock, no backpressure.
module mask_gen
    import mask_pkg::*;
#(
    parameter int unsigned NUM_RECT = 4
) (
    input  logic      iCLK,
    input  logic      iRST_N,
    mask_gen_if.slave bus
);

    localparam int unsigned CARRY    = PIPE_LAT - 1;
    localparam logic [2:0]  NUM_R3   = 3'(NUM_RECT);

    // ---------------- config banks and swap FSM ----------------
    rect_t               r_pend_rect [NUM_RECT];
    rect_t               r_act_rect  [NUM_RECT];
    rect_t               w_eff_rect  [NUM_RECT];
    logic [NUM_RECT-1:0] r_pend_en, r_act_en, w_eff_en;
    logic                r_pend_inv, r_act_inv, w_eff_inv;

    cfg_state_e r_state, w_state_next;
    logic       w_swap;
    logic       w_frame_start;
    logic       w_wr_ctrl;
    logic [2:0] w_rect_idx;
    logic       w_wr_ok;

    assign w_frame_start = bus.iDVI_VAL && (bus.iDVI_X == '0) && (bus.iDVI_Y == '0);
    assign w_wr_ctrl     = bus.iCFG_ADDR == CFG_ADDR_CTRL;
    assign w_rect_idx    = bus.iCFG_ADDR[4:2];
    assign w_wr_ok       = bus.iCFG_WE && (w_wr_ctrl || (w_rect_idx < NUM_R3));

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state <= CLEAN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A write in the swap cycle lands after the copy, so the bank stays dirty.
    always_comb begin
        w_state_next = r_state;
        w_swap       = 1'b0;
        unique case (r_state)
            CLEAN: if (w_wr_ok) w_state_next = DIRTY;
            DIRTY: if (w_frame_start) begin
                w_swap       = 1'b1;
                w_state_next = w_wr_ok ? DIRTY : CLEAN;
            end
        endcase
    end

    assign bus.oCFG_PENDING = (r_state == DIRTY);

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            for (int k = 0; k < NUM_RECT; k++) r_pend_rect[k] <= '0;
            r_pend_en  <= '0;
            r_pend_inv <= 1'b0;
        end else if (w_wr_ok) begin
            if (w_wr_ctrl) begin
                r_pend_en  <= bus.iCFG_DATA[NUM_RECT-1:0];
                r_pend_inv <= bus.iCFG_DATA[CFG_INVERT_BIT];
            end
            for (int k = 0; k < NUM_RECT; k++) begin
                if (!w_wr_ctrl && (w_rect_idx == 3'(k))) begin
                    unique case (bus.iCFG_ADDR[1:0])
                        2'd0: r_pend_rect[k].x0 <= bus.iCFG_DATA;
                        2'd1: r_pend_rect[k].y0 <= bus.iCFG_DATA;
                        2'd2: r_pend_rect[k].x1 <= bus.iCFG_DATA;
                        2'd3: r_pend_rect[k].y1 <= bus.iCFG_DATA;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            for (int k = 0; k < NUM_RECT; k++) r_act_rect[k] <= '0;
            r_act_en  <= '0;
            r_act_inv <= 1'b0;
        end else if (w_swap) begin
            for (int k = 0; k < NUM_RECT; k++) r_act_rect[k] <= r_pend_rect[k];
            r_act_en  <= r_pend_en;
            r_act_inv <= r_pend_inv;
        end
    end

    // The frame-start pixel must already see the swapped-in bank.
    always_comb begin
        for (int k = 0; k < NUM_RECT; k++) begin
            w_eff_rect[k] = w_swap ? r_pend_rect[k] : r_act_rect[k];
        end
        w_eff_en  = w_swap ? r_pend_en  : r_act_en;
        w_eff_inv = w_swap ? r_pend_inv : r_act_inv;
    end

    // ---------------- pipeline ----------------
    // Valid and coordinates ride alongside S1..S5; index 0 is S1.
    logic [CARRY-1:0] r_val;
    logic [9:0]       r_x [CARRY];
    logic [9:0]       r_y [CARRY];

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_val <= '0;
            for (int i = 0; i < CARRY; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else begin
            r_val  <= {r_val[CARRY-2:0], bus.iDVI_VAL};
            r_x[0] <= bus.iDVI_X;
            r_y[0] <= bus.iDVI_Y;
            for (int i = 1; i < CARRY; i++) begin
                r_x[i] <= r_x[i-1];
                r_y[i] <= r_y[i-1];
            end
        end
    end

    // Config is captured with the pixel and travels with it.
    rect_t               r_s1_rect [NUM_RECT];
    logic [NUM_RECT-1:0] r_s1_en, r_s2_en, r_s3_hit;
    logic                r_s1_inv, r_s2_inv, r_s3_inv, r_s4_inv;
    logic                r_s4_any, r_s5_mask;
    logic [NUM_RECT-1:0] w_s2_hit;
    logic                r_o_mask, r_o_val;
    logic [9:0]          r_o_x, r_o_y;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            for (int k = 0; k < NUM_RECT; k++) r_s1_rect[k] <= '0;
            r_s1_en   <= '0;
            r_s1_inv  <= 1'b0;
            r_s2_en   <= '0;
            r_s2_inv  <= 1'b0;
            r_s3_hit  <= '0;
            r_s3_inv  <= 1'b0;
            r_s4_any  <= 1'b0;
            r_s4_inv  <= 1'b0;
            r_s5_mask <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_RECT; k++) r_s1_rect[k] <= w_eff_rect[k];
            r_s1_en   <= w_eff_en;
            r_s1_inv  <= w_eff_inv;
            r_s2_en   <= r_s1_en;
            r_s2_inv  <= r_s1_inv;
            r_s3_hit  <= w_s2_hit & r_s2_en;
            r_s3_inv  <= r_s2_inv;
            r_s4_any  <= |r_s3_hit;
            r_s4_inv  <= r_s3_inv;
            r_s5_mask <= r_s4_any ^ r_s4_inv;
        end
    end

    for (genvar g = 0; g < NUM_RECT; g++) begin : g_rect
        mask_rect_cmp u_cmp (
            .i_clk   (iCLK),
            .i_rst_n (iRST_N),
            .i_x     (r_x[0]),
            .i_y     (r_y[0]),
            .i_rect  (r_s1_rect[g]),
            .o_hit   (w_s2_hit[g])
        );
    end

    // Output register holds its last valid pixel across bubbles.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_o_val  <= 1'b0;
            r_o_mask <= 1'b0;
            r_o_x    <= '0;
            r_o_y    <= '0;
        end else begin
            r_o_val <= r_val[CARRY-1];
            if (r_val[CARRY-1]) begin
                r_o_mask <= r_s5_mask;
                r_o_x    <= r_x[CARRY-1];
                r_o_y    <= r_y[CARRY-1];
            end
        end
    end

    assign bus.oMASK     = r_o_mask;
    assign bus.oMASK_VAL = r_o_val;
    assign bus.oMASK_X   = r_o_x;
    assign bus.oMASK_Y   = r_o_y;

endmodule

// File: tb/tb_mask_gen.sv
// tb_mask_gen: randomized scoreboard bench for mask_gen. Frames are a 40x32
// coordinate window so each frame is short.
module tb_mask_gen;

    localparam int NR = 4;
    localparam int FW = 40;
    localparam int FH = 32;
    localparam int LAT = 6;

    logic iCLK = 1'b0;
    logic iRST_N = 1'b0;

    mask_gen_if u_if ();

    mask_gen #(.NUM_RECT(NR)) u_dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (u_if)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc++;

    // ---------------- reference model ----------------
    typedef struct { int x0; int y0; int x1; int y1; } mrect_t;
    typedef struct { int mask; int x; int y; int cyc; } exp_t;

    mrect_t m_pend [NR];
    mrect_t m_act  [NR];
    int     m_pend_en, m_act_en, m_pend_inv, m_act_inv, m_dirty;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ones_cnt = 0;
    int   last_mask = 0, last_x = 0, last_y = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NR; k++) begin
            m_pend[k] = '{0, 0, 0, 0};
            m_act[k]  = '{0, 0, 0, 0};
        end
        m_pend_en = 0; m_act_en = 0; m_pend_inv = 0; m_act_inv = 0; m_dirty = 0;
    endfunction

    function automatic int model_mask(input int x, input int y);
        int any = 0;
        for (int k = 0; k < NR; k++) begin
            if (m_act_en[k] && x >= m_act[k].x0 && x <= m_act[k].x1 &&
                y >= m_act[k].y0 && y <= m_act[k].y1) any = 1;
        end
        return any ^ m_act_inv;
    endfunction

    function automatic void model_write(input int addr, input int data);
        if (addr == 31) begin
            m_pend_en  = data & ((1 << NR) - 1);
            m_pend_inv = (data >> 9) & 1;
            m_dirty    = 1;
        end else if (addr < 4 * NR) begin
            case (addr % 4)
                0: m_pend[addr / 4].x0 = data;
                1: m_pend[addr / 4].y0 = data;
                2: m_pend[addr / 4].x1 = data;
                default: m_pend[addr / 4].y1 = data;
            endcase
            m_dirty = 1;
        end
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit val, input int x, input int y,
                        input bit we, input int addr, input int data);
        exp_t e;
        u_if.iDVI_VAL  = val;
        u_if.iDVI_X    = 10'(x);
        u_if.iDVI_Y    = 10'(y);
        u_if.iCFG_WE   = we;
        u_if.iCFG_ADDR = 5'(addr);
        u_if.iCFG_DATA = 10'(data);
        if (val) begin
            if (x == 0 && y == 0 && m_dirty != 0) begin
                m_act = m_pend; m_act_en = m_pend_en; m_act_inv = m_pend_inv; m_dirty = 0;
            end
            e.mask = model_mask(x, y); e.x = x; e.y = y; e.cyc = cyc;
            q.push_back(e);
        end
        if (we) model_write(addr, data);
        @(posedge iCLK);
        #1;
        u_if.iDVI_VAL = 1'b0;
        u_if.iCFG_WE  = 1'b0;
        if (iRST_N) check("cfg_pending", int'(u_if.oCFG_PENDING), m_dirty);
    endtask

    task automatic idle();
        step(0, $urandom_range(FW - 1), $urandom_range(FH - 1), 0, 0, 0);
    endtask

    task automatic wr(input int addr, input int data);
        step(0, $urandom_range(FW - 1), $urandom_range(FH - 1), 1, addr, data);
    endtask

    task automatic frame(input int gap_pct, input bit fs_we, input int fs_addr,
                         input int fs_data, input int abort_at);
        int idx = 0;
        for (int y = 0; y < FH; y++) begin
            for (int x = 0; x < FW; x++) begin
                if (idx == abort_at) return;
                while (int'($urandom_range(99)) < gap_pct) idle();
                step(1, x, y, fs_we && idx == 0, fs_addr, fs_data);
                idx++;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            idle();
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        iRST_N = 1'b0;
        q.delete();
        last_mask = 0; last_x = 0; last_y = 0;
        model_reset();
        repeat (3) idle();
        check("rst_mask", int'(u_if.oMASK), 0);
        check("rst_val", int'(u_if.oMASK_VAL), 0);
        check("rst_x", int'(u_if.oMASK_X), 0);
        check("rst_y", int'(u_if.oMASK_Y), 0);
        check("rst_pending", int'(u_if.oCFG_PENDING), 0);
        iRST_N = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge iCLK) begin : mon
        exp_t e;
        if (iRST_N) begin
            if (u_if.oMASK_VAL) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_valid: got valid at (%0d,%0d), expected none",
                             u_if.oMASK_X, u_if.oMASK_Y);
                end else begin
                    e = q.pop_front();
                    check("mask", int'(u_if.oMASK), e.mask);
                    check("mask_x", int'(u_if.oMASK_X), e.x);
                    check("mask_y", int'(u_if.oMASK_Y), e.y);
                    check("latency", cyc - e.cyc, LAT);
                    last_mask = e.mask; last_x = e.x; last_y = e.y;
                    if (u_if.oMASK) ones_cnt++;
                end
            end else begin
                check("hold_mask", int'(u_if.oMASK), last_mask);
                check("hold_x", int'(u_if.oMASK_X), last_x);
                check("hold_y", int'(u_if.oMASK_Y), last_y);
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: got no finish, expected finish before 5ms");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        u_if.iDVI_VAL = 0; u_if.iDVI_X = 0; u_if.iDVI_Y = 0;
        u_if.iCFG_WE = 0; u_if.iCFG_ADDR = 0; u_if.iCFG_DATA = 0;
        model_reset();
        do_reset();

        // Single rect, applied only from the next frame start
        wr(0, 10); wr(1, 20); wr(2, 15); wr(3, 25); wr(31, 'h001);
        check("pending_after_write", int'(u_if.oCFG_PENDING), 1);
        ones_cnt = 0;
        for (int y = 20; y <= 25; y++)
            for (int x = 8; x <= 17; x++) step(1, x, y, 0, 0, 0);
        drain();
        check("pre_frame_ones", ones_cnt, 0);
        ones_cnt = 0;
        frame(0, 0, 0, 0, -1);
        drain();
        check("rect0_ones", ones_cnt, 36);

        // Inverted, with random bubbles
        wr(31, 'h201);
        ones_cnt = 0;
        frame(20, 0, 0, 0, -1);
        drain();
        check("invert_ones", ones_cnt, FW * FH - 36);

        // Inverted X bounds never hit
        wr(0, 50); wr(2, 40); wr(31, 'h001);
        check("pending_bad_rect", int'(u_if.oCFG_PENDING), 1);
        ones_cnt = 0;
        frame(0, 0, 0, 0, -1);
        drain();
        check("bad_rect_ones", ones_cnt, 0);
        check("pending_cleared", int'(u_if.oCFG_PENDING), 0);

        // Overlapping union
        wr(0, 0); wr(1, 0); wr(2, 3); wr(3, 3);
        wr(4, 2); wr(5, 2); wr(6, 5); wr(7, 5); wr(31, 'h003);
        ones_cnt = 0;
        frame(5, 0, 0, 0, -1);
        drain();
        check("union_ones", ones_cnt, 28);

        // Control write on the frame-start cycle while dirty
        wr(31, 'h000);
        ones_cnt = 0;
        frame(0, 1, 31, 'h002, -1);
        drain();
        check("coincident_old_ones", ones_cnt, 0);
        check("coincident_pending", int'(u_if.oCFG_PENDING), 1);
        ones_cnt = 0;
        frame(0, 0, 0, 0, -1);
        drain();
        check("coincident_new_ones", ones_cnt, 16);

        // Mid-frame reset with bubbles; no stale valid afterwards
        frame(30, 0, 0, 0, 300);
        do_reset();
        repeat (8) idle();
        ones_cnt = 0;
        frame(10, 0, 0, 0, -1);
        drain();
        check("post_reset_ones", ones_cnt, 0);

        // Random configs, including ignored addresses and frame-start writes
        for (int it = 0; it < 8; it++) begin
            int nw = $urandom_range(10, 4);
            for (int w = 0; w < nw; w++) begin
                int a = $urandom_range(31);
                int d = (a == 31) ? $urandom_range(1023)
                                  : $urandom_range(((a % 2) == 0) ? 45 : 35);
                wr(a, d);
            end
            if ($urandom_range(1) == 1)
                frame(10, 1, $urandom_range(31), $urandom_range(1023), -1);
            else
                frame(10, 0, 0, 0, -1);
            drain();
        end

        repeat (4) idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
